// File: rtl/serial_pkg.sv
// serial_pkg
//   Definitions shared by the serial transmit shifter and its matching
//   capture block: FSM state encodings and the bit-counter width helper.
//   No ports.
package serial_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Bit-counter width for a WIDTH-bit word. A 1-bit word still needs a
  // 1-bit counter so that the counter port never has zero width.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_bit_counter.sv
// serial_bit_counter
//   Tracks which bit of the current word is on the serial line.
//   Ports:
//     clk        rising-edge clock
//     rst        synchronous active-high reset (cnt -> 0)
//     load_i     load cnt with load_val_i
//     load_val_i value taken on load
//     clear_i    force cnt to 0 (wins over load and increment)
//     inc_i      advance cnt by one
//     last_o     high while cnt == WIDTH-1
module serial_bit_counter
  import serial_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int CW = cnt_width(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_i,
  input  logic [CW-1:0] load_val_i,
  input  logic          clear_i,
  input  logic          inc_i,
  output logic          last_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The owner stops incrementing at WIDTH-1, so cnt never wraps.
  assign last_o = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_tx_shifter.sv
// serial_tx_shifter
//   Parallel-in, serial-out transmit shifter. Accepts a WIDTH-bit word over
//   a valid/ready handshake and sends it one bit per clock on sdo, qualified
//   by sdo_valid. Back-to-back words stream with no gap.
//   Ports:
//     clk         rising-edge clock
//     rst         synchronous active-high reset
//     load_valid  producer offers load_data
//     load_ready  a word can be accepted this cycle (from registered state only)
//     load_data   word to serialise, sampled only on accept
//     sdo         registered serial data, 0 whenever sdo_valid is 0
//     sdo_valid   registered, sdo carries a bit this cycle
//     frame_done  high during the last bit of each word
module serial_tx_shifter
  import serial_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  output logic             sdo,
  output logic             sdo_valid,
  output logic             frame_done
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic             sdo_q, sdo_d;
  logic             sdo_valid_q, sdo_valid_d;

  logic             last;
  logic             accept;
  logic             cnt_load, cnt_clear, cnt_inc;
  logic             load_first, shreg_next_bit;
  logic [WIDTH-1:0] load_rest, shreg_shifted;

  // Bit order is fixed at elaboration: the word is shifted toward the end
  // that goes out first, so the next bit is always at the same position.
  generate
    if (LSB_FIRST) begin : g_lsb
      assign load_first     = load_data[0];
      assign load_rest      = load_data >> 1;
      assign shreg_next_bit = shreg_q[0];
      assign shreg_shifted  = shreg_q >> 1;
    end else begin : g_msb
      assign load_first     = load_data[WIDTH-1];
      assign load_rest      = load_data << 1;
      assign shreg_next_bit = shreg_q[WIDTH-1];
      assign shreg_shifted  = shreg_q << 1;
    end
  endgenerate

  // Ready while idle, or on the last bit so the next word follows with no gap.
  assign load_ready = (state_q == ST_IDLE) | ((state_q == ST_SHIFT) & last);
  assign accept     = load_valid & load_ready;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    sdo_d       = 1'b0;
    sdo_valid_d = 1'b0;
    cnt_load    = 1'b0;
    cnt_clear   = 1'b0;
    cnt_inc     = 1'b0;
    if (accept) begin
      state_d     = ST_SHIFT;
      sdo_d       = load_first;
      sdo_valid_d = 1'b1;
      shreg_d     = load_rest;
      cnt_load    = 1'b1;
    end else if (state_q == ST_SHIFT) begin
      if (last) begin
        state_d   = ST_IDLE;
        cnt_clear = 1'b1;
      end else begin
        sdo_d       = shreg_next_bit;
        sdo_valid_d = 1'b1;
        shreg_d     = shreg_shifted;
        cnt_inc     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      sdo_q       <= 1'b0;
      sdo_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      sdo_q       <= sdo_d;
      sdo_valid_q <= sdo_valid_d;
    end
  end

  serial_bit_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .load_i    (cnt_load),
    .load_val_i(CW'(0)),
    .clear_i   (cnt_clear),
    .inc_i     (cnt_inc),
    .last_o    (last)
  );

  assign sdo        = sdo_q;
  assign sdo_valid  = sdo_valid_q;
  // In IDLE the counter also sits at WIDTH-1 when WIDTH=1, hence the qualifier.
  assign frame_done = sdo_valid_q & last;

endmodule

// File: tb/tb_serial_tx_shifter.sv
// tb_serial_tx_shifter
//   Three instances share clk/rst: 8-bit LSB-first, 8-bit MSB-first and
//   1-bit. A word-level model (bits remaining + captured word) predicts every
//   output after each clock edge.
module tb_serial_tx_shifter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lv  [3];
  logic [31:0] ld  [3];
  logic        rdy [3];
  logic        sdo [3];
  logic        sv  [3];
  logic        fd  [3];

  int          w_of   [3] = '{8, 8, 1};
  int          lsb_of [3] = '{1, 0, 1};

  // Model state: bits still to be shown (including the current one) and the
  // word being sent.
  int          left   [3];
  logic [31:0] word_m [3];
  logic        acc    [3];
  logic        e_sdo  [3];
  logic        e_sv   [3];
  logic        e_fd   [3];
  logic        e_rdy  [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_tx_shifter #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_lsb8 (
    .clk(clk), .rst(rst), .load_valid(lv[0]), .load_ready(rdy[0]),
    .load_data(ld[0][7:0]), .sdo(sdo[0]), .sdo_valid(sv[0]), .frame_done(fd[0]));

  serial_tx_shifter #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_msb8 (
    .clk(clk), .rst(rst), .load_valid(lv[1]), .load_ready(rdy[1]),
    .load_data(ld[1][7:0]), .sdo(sdo[1]), .sdo_valid(sv[1]), .frame_done(fd[1]));

  serial_tx_shifter #(.WIDTH(1), .LSB_FIRST(1'b1)) dut_w1 (
    .clk(clk), .rst(rst), .load_valid(lv[2]), .load_ready(rdy[2]),
    .load_data(ld[2][0:0]), .sdo(sdo[2]), .sdo_valid(sv[2]), .frame_done(fd[2]));

  // Advance one clock: update the model from the inputs seen at the edge,
  // derive expected outputs, then move 1 time unit past the edge.
  task automatic tick();
    int pos;
    int idx;
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      acc[d] = 1'b0;
      if (rst) begin
        left[d] = 0;
      end else if (lv[d] && left[d] <= 1) begin
        word_m[d] = ld[d];
        left[d]   = w_of[d];
        acc[d]    = 1'b1;
      end else if (left[d] > 0) begin
        left[d] = left[d] - 1;
      end
      e_sv[d]  = (left[d] > 0);
      e_fd[d]  = (left[d] == 1);
      e_rdy[d] = (left[d] <= 1);
      e_sdo[d] = 1'b0;
      if (left[d] > 0) begin
        pos      = w_of[d] - left[d];
        idx      = (lsb_of[d] != 0) ? pos : (w_of[d] - 1 - pos);
        e_sdo[d] = word_m[d][idx];
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) rst = 1'b0;
      tick();
      for (int d = 0; d < 3; d++) begin
        checks += 4;
        if (sdo[d] !== e_sdo[d]) begin errors++; $display("FAIL reset_sdo dut%0d cyc%0d: got %b exp %b", d, c, sdo[d], e_sdo[d]); end
        if (sv[d]  !== e_sv[d])  begin errors++; $display("FAIL reset_valid dut%0d cyc%0d: got %b exp %b", d, c, sv[d], e_sv[d]); end
        if (fd[d]  !== e_fd[d])  begin errors++; $display("FAIL reset_done dut%0d cyc%0d: got %b exp %b", d, c, fd[d], e_fd[d]); end
        if (rdy[d] !== e_rdy[d]) begin errors++; $display("FAIL reset_ready dut%0d cyc%0d: got %b exp %b", d, c, rdy[d], e_rdy[d]); end
      end
      $display("reset cyc%0d: rst=%b ready=%b%b%b", c, rst, rdy[0], rdy[1], rdy[2]);
    end
  endtask

  task automatic test_lsb_a5();
    logic [7:0] got;
    got = '0;
    ld[0] = 32'hA5;
    lv[0] = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      lv[0] = 1'b0;
      if (c <= 8) got[c-1] = sdo[0];
      checks += 4;
      if (sdo[0] !== e_sdo[0]) begin errors++; $display("FAIL lsb_sdo cyc%0d: got %b exp %b", c, sdo[0], e_sdo[0]); end
      if (sv[0]  !== e_sv[0])  begin errors++; $display("FAIL lsb_valid cyc%0d: got %b exp %b", c, sv[0], e_sv[0]); end
      if (fd[0]  !== e_fd[0])  begin errors++; $display("FAIL lsb_done cyc%0d: got %b exp %b", c, fd[0], e_fd[0]); end
      if (rdy[0] !== e_rdy[0]) begin errors++; $display("FAIL lsb_ready cyc%0d: got %b exp %b", c, rdy[0], e_rdy[0]); end
      $display("lsb_a5 cyc%0d: sdo=%b valid=%b done=%b ready=%b", c, sdo[0], sv[0], fd[0], rdy[0]);
    end
    checks++;
    if (got !== 8'hA5) begin errors++; $display("FAIL lsb_word: got %h exp a5", got); end
  endtask

  task automatic test_back_to_back();
    int nvalid;
    int ndone;
    nvalid = 0;
    ndone  = 0;
    ld[0] = 32'hA5;
    lv[0] = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      tick();
      if (c == 1) ld[0] = 32'h3C;
      else if (acc[0]) lv[0] = 1'b0;
      if (sv[0] === 1'b1 && c <= 16) nvalid++;
      if (fd[0] === 1'b1) ndone++;
      checks += 4;
      if (sdo[0] !== e_sdo[0]) begin errors++; $display("FAIL b2b_sdo cyc%0d: got %b exp %b", c, sdo[0], e_sdo[0]); end
      if (sv[0]  !== e_sv[0])  begin errors++; $display("FAIL b2b_valid cyc%0d: got %b exp %b", c, sv[0], e_sv[0]); end
      if (fd[0]  !== e_fd[0])  begin errors++; $display("FAIL b2b_done cyc%0d: got %b exp %b", c, fd[0], e_fd[0]); end
      if (rdy[0] !== e_rdy[0]) begin errors++; $display("FAIL b2b_ready cyc%0d: got %b exp %b", c, rdy[0], e_rdy[0]); end
      $display("b2b cyc%0d: sdo=%b valid=%b done=%b ready=%b", c, sdo[0], sv[0], fd[0], rdy[0]);
    end
    checks += 2;
    if (nvalid != 16) begin errors++; $display("FAIL b2b_valid_run: got %0d exp 16", nvalid); end
    if (ndone != 2)   begin errors++; $display("FAIL b2b_done_count: got %0d exp 2", ndone); end
  endtask

  task automatic test_msb_80();
    logic [7:0] got;
    got = '0;
    ld[1] = 32'h80;
    lv[1] = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      lv[1] = 1'b0;
      if (c <= 8) got = {got[6:0], sdo[1]};
      checks += 4;
      if (sdo[1] !== e_sdo[1]) begin errors++; $display("FAIL msb_sdo cyc%0d: got %b exp %b", c, sdo[1], e_sdo[1]); end
      if (sv[1]  !== e_sv[1])  begin errors++; $display("FAIL msb_valid cyc%0d: got %b exp %b", c, sv[1], e_sv[1]); end
      if (fd[1]  !== e_fd[1])  begin errors++; $display("FAIL msb_done cyc%0d: got %b exp %b", c, fd[1], e_fd[1]); end
      if (rdy[1] !== e_rdy[1]) begin errors++; $display("FAIL msb_ready cyc%0d: got %b exp %b", c, rdy[1], e_rdy[1]); end
      $display("msb_80 cyc%0d: sdo=%b valid=%b done=%b ready=%b", c, sdo[1], sv[1], fd[1], rdy[1]);
    end
    checks++;
    if (got !== 8'h80) begin errors++; $display("FAIL msb_word: got %h exp 80", got); end
  endtask

  task automatic test_abort();
    int ndone;
    ndone = 0;
    ld[0] = 32'hFF;
    lv[0] = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c == 1) begin ld[0] = 32'h00; lv[0] = 1'b1; end
      if (c == 3) lv[0] = 1'b0;
      rst = (c == 4);
      if (fd[0] === 1'b1) ndone++;
      checks += 4;
      if (sdo[0] !== e_sdo[0]) begin errors++; $display("FAIL abort_sdo cyc%0d: got %b exp %b", c, sdo[0], e_sdo[0]); end
      if (sv[0]  !== e_sv[0])  begin errors++; $display("FAIL abort_valid cyc%0d: got %b exp %b", c, sv[0], e_sv[0]); end
      if (fd[0]  !== e_fd[0])  begin errors++; $display("FAIL abort_done cyc%0d: got %b exp %b", c, fd[0], e_fd[0]); end
      if (rdy[0] !== e_rdy[0]) begin errors++; $display("FAIL abort_ready cyc%0d: got %b exp %b", c, rdy[0], e_rdy[0]); end
      $display("abort cyc%0d: sdo=%b valid=%b done=%b ready=%b", c, sdo[0], sv[0], fd[0], rdy[0]);
    end
    checks++;
    if (ndone != 0) begin errors++; $display("FAIL abort_done_count: got %0d exp 0", ndone); end
  endtask

  task automatic test_width1();
    logic [2:0] stream;
    int ndone;
    stream = 3'b101;
    ndone  = 0;
    lv[2]  = 1'b1;
    ld[2]  = {31'd0, stream[0]};
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c < 3) ld[2] = {31'd0, stream[c]};
      else lv[2] = 1'b0;
      if (fd[2] === 1'b1) ndone++;
      checks += 4;
      if (sdo[2] !== e_sdo[2]) begin errors++; $display("FAIL w1_sdo cyc%0d: got %b exp %b", c, sdo[2], e_sdo[2]); end
      if (sv[2]  !== e_sv[2])  begin errors++; $display("FAIL w1_valid cyc%0d: got %b exp %b", c, sv[2], e_sv[2]); end
      if (fd[2]  !== e_fd[2])  begin errors++; $display("FAIL w1_done cyc%0d: got %b exp %b", c, fd[2], e_fd[2]); end
      if (rdy[2] !== e_rdy[2]) begin errors++; $display("FAIL w1_ready cyc%0d: got %b exp %b", c, rdy[2], e_rdy[2]); end
      $display("width1 cyc%0d: sdo=%b valid=%b done=%b ready=%b", c, sdo[2], sv[2], fd[2], rdy[2]);
    end
    checks++;
    if (ndone != 3) begin errors++; $display("FAIL w1_done_count: got %0d exp 3", ndone); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      // The producer holds an offered word until the model says it was taken.
      for (int d = 0; d < 3; d++) begin
        if (!(lv[d] && !acc[d])) begin
          lv[d] = ($urandom_range(0, 3) != 0);
          ld[d] = $urandom;
        end
      end
      rst = ($urandom_range(0, 59) == 0);
      tick();
      for (int d = 0; d < 3; d++) begin
        checks += 4;
        if (sdo[d] !== e_sdo[d]) begin errors++; $display("FAIL rand_sdo dut%0d cyc%0d: got %b exp %b", d, c, sdo[d], e_sdo[d]); end
        if (sv[d]  !== e_sv[d])  begin errors++; $display("FAIL rand_valid dut%0d cyc%0d: got %b exp %b", d, c, sv[d], e_sv[d]); end
        if (fd[d]  !== e_fd[d])  begin errors++; $display("FAIL rand_done dut%0d cyc%0d: got %b exp %b", d, c, fd[d], e_fd[d]); end
        if (rdy[d] !== e_rdy[d]) begin errors++; $display("FAIL rand_ready dut%0d cyc%0d: got %b exp %b", d, c, rdy[d], e_rdy[d]); end
      end
      $display("random cyc%0d: rst=%b sdo=%b%b%b valid=%b%b%b", c, rst,
               sdo[0], sdo[1], sdo[2], sv[0], sv[1], sv[2]);
    end
    rst = 1'b0;
    for (int d = 0; d < 3; d++) lv[d] = 1'b0;
    repeat (10) tick();
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      lv[d]     = 1'b0;
      ld[d]     = '0;
      left[d]   = 0;
      word_m[d] = '0;
      acc[d]    = 1'b0;
    end
    test_reset();
    test_lsb_a5();
    test_back_to_back();
    test_msb_80();
    test_abort();
    test_width1();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
